// File: rtl/md_pkg.sv
// Shared types and constants for the motion-update sweep.
package md_pkg;

    localparam int PARTICLE_W = 97;
    localparam int N_CELL     = 27;
    localparam int DEPTH      = 64;
    localparam int ADDR_W     = 6;
    localparam int CELL_W     = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        COMPUTE = 3'd3,
        WRITE   = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Saturating increment for the moved-particle counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/motion_update_ctrl.sv
// Sweeps every slot of every cell memory, pushes each valid particle through
// the external cell-index datapath and writes it to its destination cell.
module motion_update_ctrl
    import md_pkg::*;
#(
    parameter int N_CELL = md_pkg::N_CELL,
    parameter int DEPTH  = md_pkg::DEPTH,
    parameter int ADDR_W = md_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [CELL_W-1:0]     rd_cell,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [PARTICLE_W-1:0] rd_pos,
    input  logic [PARTICLE_W-1:0] rd_vel,
    output logic [PARTICLE_W-1:0] cidx_p,
    output logic [PARTICLE_W-1:0] cidx_v,
    input  logic [32:0]           cidx_index,
    input  logic [PARTICLE_W-1:0] cidx_newp,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [CELL_W-1:0]     wr_cell,
    output logic [PARTICLE_W-1:0] wr_data,
    output logic [15:0]           moved_cnt,
    output logic                  err
);

    localparam logic [ADDR_W-1:0]     LAST_SLOT = ADDR_W'(DEPTH - 1);
    localparam logic [CELL_W-1:0]     LAST_CELL = CELL_W'(N_CELL - 1);
    localparam logic [PARTICLE_W-1:0] VALID_BIT = {1'b1, {(PARTICLE_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [CELL_W-1:0]       cell_q, cell_d;
    logic [ADDR_W-1:0]       slot_q, slot_d;
    logic                    force_adv_q, force_adv_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_en_q, rd_en_d;
    logic [CELL_W-1:0]       rd_cell_q, rd_cell_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [PARTICLE_W-1:0]   cidx_p_q, cidx_p_d;
    logic [PARTICLE_W-1:0]   cidx_v_q, cidx_v_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [CELL_W-1:0]       wr_cell_q, wr_cell_d;
    logic [PARTICLE_W-1:0]   wr_data_q, wr_data_d;
    logic [15:0]             moved_q, moved_d;
    logic                    err_q, err_d;

    // Next-state, counter and datapath-register logic; outputs are decoded
    // from the next state so every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cell_d      = cell_q;
        slot_d      = slot_q;
        force_adv_d = force_adv_q;
        rd_cell_d   = rd_cell_q;
        rd_addr_d   = rd_addr_q;
        cidx_p_d    = cidx_p_q;
        cidx_v_d    = cidx_v_q;
        wr_cell_d   = wr_cell_q;
        wr_data_d   = wr_data_q;
        moved_d     = moved_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cell_d      = {CELL_W{1'b0}};
                    slot_d      = {ADDR_W{1'b0}};
                    force_adv_d = 1'b0;
                    moved_d     = 16'd0;
                    err_d       = 1'b0;
                    state_d     = READ;
                end else begin
                    state_d     = IDLE;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                cidx_p_d = rd_pos;
                cidx_v_d = rd_vel;
                if (!rd_pos[PARTICLE_W-1]) begin
                    // An empty slot ends the occupied region of this cell.
                    force_adv_d = 1'b1;
                    state_d     = NEXT;
                end else begin
                    state_d     = COMPUTE;
                end
            end
            COMPUTE: begin
                if (cidx_index >= 33'(N_CELL)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    wr_cell_d = cidx_index[CELL_W-1:0];
                    wr_data_d = cidx_newp | VALID_BIT;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    moved_d = sat_inc16(moved_q);
                    state_d = NEXT;
                end else begin
                    state_d = WRITE;
                end
            end
            NEXT: begin
                force_adv_d = 1'b0;
                if (force_adv_q || (slot_q == LAST_SLOT)) begin
                    slot_d = {ADDR_W{1'b0}};
                    if (cell_q == LAST_CELL) begin
                        state_d = DONE;
                    end else begin
                        cell_d  = cell_q + 5'd1;
                        state_d = READ;
                    end
                end else begin
                    slot_d  = slot_q + ADDR_W'(1);
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_en_d    = (state_d == READ);
        wr_valid_d = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        if (state_d == READ) begin
            rd_cell_d = cell_d;
            rd_addr_d = slot_d;
        end else begin
            rd_cell_d = rd_cell_q;
            rd_addr_d = rd_addr_q;
        end
    end

    // State and output registers; reset abandons any sweep or pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cell_q      <= {CELL_W{1'b0}};
            slot_q      <= {ADDR_W{1'b0}};
            force_adv_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_cell_q   <= {CELL_W{1'b0}};
            rd_addr_q   <= {ADDR_W{1'b0}};
            cidx_p_q    <= {PARTICLE_W{1'b0}};
            cidx_v_q    <= {PARTICLE_W{1'b0}};
            wr_valid_q  <= 1'b0;
            wr_cell_q   <= {CELL_W{1'b0}};
            wr_data_q   <= {PARTICLE_W{1'b0}};
            moved_q     <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cell_q      <= cell_d;
            slot_q      <= slot_d;
            force_adv_q <= force_adv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_cell_q   <= rd_cell_d;
            rd_addr_q   <= rd_addr_d;
            cidx_p_q    <= cidx_p_d;
            cidx_v_q    <= cidx_v_d;
            wr_valid_q  <= wr_valid_d;
            wr_cell_q   <= wr_cell_d;
            wr_data_q   <= wr_data_d;
            moved_q     <= moved_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_cell   = rd_cell_q;
    assign rd_addr   = rd_addr_q;
    assign cidx_p    = cidx_p_q;
    assign cidx_v    = cidx_v_q;
    assign wr_valid  = wr_valid_q;
    assign wr_cell   = wr_cell_q;
    assign wr_data   = wr_data_q;
    assign moved_cnt = moved_q;
    assign err       = err_q;

endmodule

// File: doc/motion_update_ctrl.md
MOTION_UPDATE_CTRL -- requirements
Module: motion_update_ctrl

Interface
REQ-001 The block SHALL take parameter N_CELL, default 27, as the number of cell memories scanned.
REQ-002 The block SHALL take parameter DEPTH, default 64, as the particle slots per cell memory.
REQ-003 The block SHALL take parameter ADDR_W, default 6, as the slot address width (log2 DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, with asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a full motion-update sweep.
REQ-007 The block SHALL have ports busy and done, output, 1 bit each: busy high while sweeping; done a one-cycle pulse at sweep end.
REQ-008 The block SHALL have ports rd_en (output, 1), rd_cell (output, 5), rd_addr (output, ADDR_W), rd_pos and rd_vel (input, 97 each) forming the cell-memory read port, data valid exactly 1 cycle after rd_en.
REQ-009 The block SHALL have ports cidx_p and cidx_v (output, 97 each) driving the cell-index datapath, and cidx_index (input, 33) and cidx_newp (input, 97) returning its combinational result.
REQ-010 The block SHALL have ports wr_valid (output, 1), wr_ready (input, 1), wr_cell (output, 5) and wr_data (output, 97) forming the destination-cell write handshake.
REQ-011 The block SHALL have ports moved_cnt (output, 16) counting particles written in the current sweep, and err (output, 1) as a sticky out-of-range flag.

Function
REQ-012 The FSM SHALL use states IDLE, READ, WAIT, COMPUTE, WRITE, NEXT and DONE.
REQ-013 From IDLE with start high, the FSM SHALL clear the cell/slot counters and moved_cnt, and go to READ; start is ignored in all other states.
REQ-014 In READ, the FSM SHALL drive rd_en=1 with rd_cell/rd_addr set to the current counters for one cycle, then go to WAIT.
REQ-015 In WAIT, the FSM SHALL capture rd_pos/rd_vel into registers driving cidx_p/cidx_v; if rd_pos[96]=0 (empty slot), it SHALL go to NEXT with cell-advance forced, otherwise go to COMPUTE.
REQ-016 In COMPUTE, the FSM SHALL register cidx_index[4:0] and cidx_newp into wr_cell/wr_data with wr_data[96] forced 1, then go to WRITE.
REQ-017 If the registered index in COMPUTE is >= N_CELL, the FSM SHALL set err, drop the particle and go to NEXT.
REQ-018 In WRITE, the block SHALL hold wr_valid=1 with wr_cell/wr_data stable until wr_ready=1; on that handshake cycle it SHALL increment moved_cnt (saturating at 0xFFFF) and go to NEXT.
REQ-019 In NEXT, the block SHALL increment the slot; at slot DEPTH-1, or on forced advance, it SHALL reset the slot to 0 and increment the cell; after cell N_CELL-1 it SHALL go to DONE, otherwise to READ.
REQ-020 DONE SHALL pulse done for one cycle and return to IDLE; busy SHALL be high in every state except IDLE.
REQ-021 Minimum per-particle latency SHALL be 5 cycles (READ, WAIT, COMPUTE, WRITE with wr_ready=1, NEXT); each empty slot SHALL cost 3 cycles.
REQ-022 rd_en and wr_valid SHALL never be high in the same cycle.

Reset
REQ-023 On rst, the FSM SHALL go to IDLE immediately, including mid-sweep and mid-WRITE, with no write completing.
REQ-024 On rst, busy, done, rd_en, wr_valid and err SHALL be 0, and rd_cell, rd_addr, wr_cell, wr_data, cidx_p, cidx_v and moved_cnt SHALL be all-zero.
REQ-025 err SHALL clear only on rst or on an accepted start.

Structure
REQ-026 Shared package md_pkg SHALL hold PARTICLE_W=97, N_CELL, DEPTH, ADDR_W, CELL_W=5 and the state enum.
REQ-027 The block SHALL instantiate no sub-module; CellIndex is instantiated beside it at the parent level.

Verification
REQ-028 Scenario: reset mid-WRITE with wr_ready=0 -> next cycle state IDLE, wr_valid=0, moved_cnt=0.
REQ-029 Scenario: N_CELL=2, DEPTH=4, all slots valid, stub cidx_index=1, wr_ready always 1 -> 8 writes to wr_cell=1, moved_cnt=8, done after 40 busy cycles.
REQ-030 Scenario: cell 0 slot 1 empty -> cell 0 yields 1 write, scan resumes at cell 1 slot 0.
REQ-031 Scenario: stub cidx_index=27 -> err=1, no wr_valid for that particle, sweep completes.
REQ-032 Scenario: wr_ready held low 10 cycles -> wr_valid, wr_cell and wr_data stable for all 10 cycles, one write counted.
REQ-033 Scenario: start pulsed while busy -> ignored; moved_cnt not cleared.
